// File: rtl/ysyx_23060136_ifu_fetch_pkg.sv
// Shared fetch-stage definitions: widths, reset PC,
// canonical NOP and the fetch FSM state encoding.
package ysyx_23060136_DEFINES;

  localparam int BITS_W = 32;
  localparam int INST_W = 32;

  localparam logic [BITS_W-1:0] ysyx_23060136_PC_RST =
    32'h8000_0000;
  localparam logic [INST_W-1:0] ysyx_23060136_NOP =
    32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

endpackage

// File: rtl/ysyx_23060136_ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one AXI4-Lite
// read per instruction and holds it until IF/ID accepts it.
module ysyx_23060136_ifu_fetch
  import ysyx_23060136_DEFINES::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              BRANCH_flushIF,
  input  logic [BITS_W-1:0] BRANCH_target,
  input  logic              FORWARD_stallID,
  output logic [BITS_W-1:0] IFU_o_pc,
  output logic [INST_W-1:0] IFU_o_inst,
  output logic              IFU_o_valid,
  output logic              IFU_o_fault,
  output logic [BITS_W-1:0] ifu_araddr,
  output logic              ifu_arvalid,
  input  logic              ifu_arready,
  input  logic [INST_W-1:0] ifu_rdata,
  input  logic [1:0]        ifu_rresp,
  input  logic              ifu_rvalid,
  output logic              ifu_rready
);

  fetch_state_e state, n_state;

  logic              started;
  logic [BITS_W-1:0] pc_q, n_pc;
  logic [BITS_W-1:0] araddr_q, n_araddr;
  logic [INST_W-1:0] inst_q, n_inst;
  logic              fault_q, n_fault;
  logic              discard_q, n_discard;

  logic redirect, accept, misaligned;
  logic ar_hs, r_hs;

  assign redirect   = BRANCH_flushIF & ~FORWARD_stallID;
  assign accept     = IFU_o_valid & ~FORWARD_stallID;
  assign misaligned = |araddr_q[1:0];
  assign ar_hs      = ifu_arvalid & ifu_arready;
  assign r_hs       = ifu_rvalid & ifu_rready;

  // started keeps arvalid low for the reset cycle itself
  assign ifu_arvalid = started & (state == S_REQ) & ~misaligned;
  assign ifu_rready  = (state == S_WAIT);
  assign IFU_o_valid = (state == S_HOLD);
  assign ifu_araddr  = araddr_q;
  assign IFU_o_pc    = pc_q;
  assign IFU_o_inst  = IFU_o_valid ? inst_q : ysyx_23060136_NOP;
  assign IFU_o_fault = IFU_o_valid & fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_REQ;
      started <= 1'b0;
    end else begin
      state   <= n_state;
      started <= 1'b1;
    end
  end

  always_comb begin
    n_state   = state;
    n_pc      = pc_q;
    n_araddr  = araddr_q;
    n_inst    = inst_q;
    n_fault   = fault_q;
    n_discard = discard_q;
    unique case (state)
      S_REQ: begin
        if (misaligned) begin
          if (redirect) begin
            n_pc     = BRANCH_target;
            n_araddr = BRANCH_target;
          end else begin
            n_state = S_HOLD;
            n_fault = 1'b1;
            n_inst  = ysyx_23060136_NOP;
          end
        end else begin
          if (ar_hs) n_state = S_WAIT;
          if (redirect) begin
            n_pc      = BRANCH_target;
            n_discard = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_hs) begin
          n_discard = 1'b0;
          if (redirect) begin
            n_pc     = BRANCH_target;
            n_araddr = BRANCH_target;
            n_state  = S_REQ;
          end else if (discard_q) begin
            n_araddr = pc_q;
            n_state  = S_REQ;
          end else begin
            n_inst  = ifu_rdata;
            n_fault = |ifu_rresp;
            n_state = S_HOLD;
          end
        end else if (redirect) begin
          n_pc      = BRANCH_target;
          n_discard = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          n_pc     = BRANCH_target;
          n_araddr = BRANCH_target;
          n_inst   = ysyx_23060136_NOP;
          n_fault  = 1'b0;
          n_state  = S_REQ;
        end else if (accept) begin
          n_pc     = pc_q + 32'd4;
          n_araddr = pc_q + 32'd4;
          n_state  = S_REQ;
        end
      end
      default: n_state = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= ysyx_23060136_PC_RST;
      araddr_q  <= ysyx_23060136_PC_RST;
      inst_q    <= ysyx_23060136_NOP;
      fault_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      pc_q      <= n_pc;
      araddr_q  <= n_araddr;
      inst_q    <= n_inst;
      fault_q   <= n_fault;
      discard_q <= n_discard;
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
// Scoreboard bench for the fetch stage with a small
// AXI4-Lite read slave of programmable latency.
module tb_ysyx_23060136_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        BRANCH_flushIF;
  logic [31:0] BRANCH_target;
  logic        FORWARD_stallID;
  logic [31:0] IFU_o_pc;
  logic [31:0] IFU_o_inst;
  logic        IFU_o_valid;
  logic        IFU_o_fault;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;

  int tests = 0;
  int fails = 0;
  int rlat;
  logic [31:0] err_addr;

  logic [31:0] ar_q[$];
  exp_t        exp_q[$];

  ysyx_23060136_ifu_fetch dut (
    .clk(clk),
    .rst(rst),
    .BRANCH_flushIF(BRANCH_flushIF),
    .BRANCH_target(BRANCH_target),
    .FORWARD_stallID(FORWARD_stallID),
    .IFU_o_pc(IFU_o_pc),
    .IFU_o_inst(IFU_o_inst),
    .IFU_o_valid(IFU_o_valid),
    .IFU_o_fault(IFU_o_fault),
    .ifu_araddr(ifu_araddr),
    .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp),
    .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc,
                          input logic [31:0] inst,
                          input logic f);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    e.fault = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!IFU_o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_valid"}, {31'd0, IFU_o_valid}, 32'd1);
  endtask

  task automatic accept_one(input string nm);
    wait_valid(nm);
    FORWARD_stallID = 1'b0;
    @(posedge clk); #1;
    FORWARD_stallID = 1'b1;
  endtask

  // bus slave: data is a fixed function of the address
  initial begin
    logic        s_ar, s_r, pend;
    logic [31:0] s_a, pa;
    int          cnt;
    pend = 1'b0;
    cnt = 0;
    pa = '0;
    ifu_arready = 1'b1;
    ifu_rvalid = 1'b0;
    ifu_rdata = '0;
    ifu_rresp = 2'b00;
    forever begin
      @(negedge clk);
      s_ar = rst && ifu_arvalid && ifu_arready;
      s_r = rst && ifu_rvalid && ifu_rready;
      s_a = ifu_araddr;
      @(posedge clk); #1;
      if (!rst) begin
        ifu_rvalid = 1'b0;
        pend = 1'b0;
      end else begin
        if (s_r) ifu_rvalid = 1'b0;
        if (s_ar) begin
          pa = s_a;
          cnt = rlat;
          pend = 1'b1;
        end
        if (pend) begin
          if (cnt == 0) begin
            ifu_rvalid = 1'b1;
            ifu_rdata = pa ^ 32'h8000_0000 ^ 32'h0050_0093;
            ifu_rresp = (pa == err_addr) ? 2'b10 : 2'b00;
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // monitor: AR addresses and accepted instructions
  always @(negedge clk) begin
    logic [31:0] ea;
    exp_t        ee;
    if (rst) begin
      if (ifu_arvalid && ifu_arready) begin
        if (ar_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ar_extra: got %h want none", ifu_araddr);
        end else begin
          ea = ar_q.pop_front();
          chk("araddr", ifu_araddr, ea);
        end
      end
      if (IFU_o_valid && !FORWARD_stallID && !BRANCH_flushIF) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_extra: got pc %h want none", IFU_o_pc);
        end else begin
          ee = exp_q.pop_front();
          chk("out_pc", IFU_o_pc, ee.pc);
          chk("out_inst", IFU_o_inst, ee.inst);
          chk("out_fault", {31'd0, IFU_o_fault}, {31'd0, ee.fault});
        end
      end
    end
  end

  initial begin
    bit found, badv;
    rst = 1'b1;
    BRANCH_flushIF = 1'b0;
    BRANCH_target = '0;
    FORWARD_stallID = 1'b1;
    rlat = 0;
    err_addr = 32'h8000_0104;
    #1 rst = 1'b0;
    #12;
    chk("rst_arvalid", {31'd0, ifu_arvalid}, 0);
    chk("rst_rready", {31'd0, ifu_rready}, 0);
    chk("rst_valid", {31'd0, IFU_o_valid}, 0);
    chk("rst_pc", IFU_o_pc, 32'h8000_0000);
    chk("rst_araddr", ifu_araddr, 32'h8000_0000);
    chk("rst_inst", IFU_o_inst, NOP);
    chk("rst_fault", {31'd0, IFU_o_fault}, 0);

    @(posedge clk); #1;
    ar_q.push_back(32'h8000_0000);
    push_exp(32'h8000_0000, 32'h0050_0093, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("c1_arvalid", {31'd0, ifu_arvalid}, 1);
    @(posedge clk); #1;
    chk("c2_rready", {31'd0, ifu_rready}, 1);
    chk("c2_valid", {31'd0, IFU_o_valid}, 0);
    @(posedge clk); #1;
    chk("c3_valid", {31'd0, IFU_o_valid}, 1);
    chk("c3_pc", IFU_o_pc, 32'h8000_0000);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, IFU_o_valid}, 1);
      chk("stall_pc", IFU_o_pc, 32'h8000_0000);
      chk("stall_inst", IFU_o_inst, 32'h0050_0093);
      chk("stall_arvalid", {31'd0, ifu_arvalid}, 0);
    end
    FORWARD_stallID = 1'b0;
    @(posedge clk); #1;
    FORWARD_stallID = 1'b1;
    chk("adv_pc", IFU_o_pc, 32'h8000_0004);
    chk("adv_araddr", ifu_araddr, 32'h8000_0004);

    ar_q.push_back(32'h8000_0004);
    push_exp(32'h8000_0004, 32'h0050_0097, 1'b0);
    accept_one("i1");

    ar_q.push_back(32'h8000_0008);
    ar_q.push_back(32'h8000_0100);
    push_exp(32'h8000_0100, 32'h0050_0193, 1'b0);
    rlat = 2;
    @(posedge clk); #1;
    chk("wait_rready", {31'd0, ifu_rready}, 1);
    BRANCH_flushIF = 1'b1;
    BRANCH_target = 32'h8000_0100;
    FORWARD_stallID = 1'b0;
    @(posedge clk); #1;
    BRANCH_flushIF = 1'b0;
    FORWARD_stallID = 1'b1;
    found = 1'b0;
    badv = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (IFU_o_valid) badv = 1'b1;
      if (ifu_arvalid && ifu_araddr == 32'h8000_0100)
        found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    rlat = 0;
    chk("disc_refetch", {31'd0, found}, 1);
    chk("disc_novalid", {31'd0, badv}, 0);

    wait_valid("i2");
    BRANCH_flushIF = 1'b1;
    BRANCH_target = 32'h8000_0200;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("fs_valid", {31'd0, IFU_o_valid}, 1);
      chk("fs_pc", IFU_o_pc, 32'h8000_0100);
    end
    BRANCH_flushIF = 1'b0;
    chk("fs_inst", IFU_o_inst, 32'h0050_0193);
    accept_one("i2");

    ar_q.push_back(32'h8000_0104);
    push_exp(32'h8000_0104, 32'h0050_0197, 1'b1);
    wait_valid("err");
    chk("err_fault", {31'd0, IFU_o_fault}, 1);
    chk("err_pc", IFU_o_pc, 32'h8000_0104);
    accept_one("err");

    ar_q.push_back(32'h8000_0108);
    wait_valid("i4");
    chk("i4_pc", IFU_o_pc, 32'h8000_0108);
    chk("i4_inst", IFU_o_inst, 32'h0050_019b);
    BRANCH_flushIF = 1'b1;
    BRANCH_target = 32'h8000_0102;
    FORWARD_stallID = 1'b0;
    @(posedge clk); #1;
    BRANCH_flushIF = 1'b0;
    FORWARD_stallID = 1'b1;
    chk("mis_arvalid", {31'd0, ifu_arvalid}, 0);
    chk("mis_pc", IFU_o_pc, 32'h8000_0102);
    @(posedge clk); #1;
    chk("mis_valid", {31'd0, IFU_o_valid}, 1);
    chk("mis_fault", {31'd0, IFU_o_fault}, 1);
    chk("mis_inst", IFU_o_inst, NOP);

    ar_q.push_back(32'h8000_0200);
    rlat = 3;
    BRANCH_flushIF = 1'b1;
    BRANCH_target = 32'h8000_0200;
    FORWARD_stallID = 1'b0;
    @(posedge clk); #1;
    BRANCH_flushIF = 1'b0;
    FORWARD_stallID = 1'b1;
    @(posedge clk); #1;
    chk("r2_rready", {31'd0, ifu_rready}, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_arvalid", {31'd0, ifu_arvalid}, 0);
    chk("ar_rready", {31'd0, ifu_rready}, 0);
    chk("ar_valid", {31'd0, IFU_o_valid}, 0);
    chk("ar_pc", IFU_o_pc, 32'h8000_0000);
    chk("ar_araddr", ifu_araddr, 32'h8000_0000);
    repeat (2) @(posedge clk);
    #1;
    rlat = 0;
    ar_q.push_back(32'h8000_0000);
    push_exp(32'h8000_0000, 32'h0050_0093, 1'b0);
    rst = 1'b1;
    accept_one("post_rst");
    ifu_arready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_q_empty", ar_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
